dual_issue_ctrl: RTL

//  Issue scheduler between the instruction queue and the two decode slots of the dual-issue pipeline.

---
 rtl/gemini_issue_pkg.sv | 16 +
 rtl/dual_issue_ctrl_if.sv | 39 +++
 rtl/issue_pair_check.sv | 38 +++
 rtl/dual_issue_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/gemini_issue_pkg.sv
// Shared definitions for the dual-issue scheduler: FSM state encoding and
// the per-cycle issue/pop counts.
package gemini_issue_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SOLO   = 2'd2,
    ST_SERIAL = 2'd3
  } state_t;

  localparam logic [1:0] POP_NONE = 2'd0;
  localparam logic [1:0] POP_ONE  = 2'd1;
  localparam logic [1:0] POP_TWO  = 2'd2;

endpackage

// File: rtl/dual_issue_ctrl_if.sv
// Queue-head, decode handshake and issue-register bundle of the dual-issue
// scheduler. slave = scheduler side, master = queue/decode side.
interface dual_issue_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic [1:0]       iq_valid;
  logic [31:0]      iq_instr0, iq_instr1;
  logic [PC_W-1:0]  iq_pc0, iq_pc1;
  logic             pd_branch0, pd_branch1;
  logic             pd_trap0, pd_trap1;
  logic             pd_hilo0, pd_hilo1;
  logic [4:0]       pd_rs1, pd_rt1;
  logic             wr_en0;
  logic [4:0]       wr_reg0;
  logic             id_ready, flush, backend_empty;

  logic [1:0]       iq_pop;
  logic [1:0]       issue_valid;
  logic [31:0]      issue_instr0, issue_instr1;
  logic [PC_W-1:0]  issue_pc0, issue_pc1;
  logic [CNT_W-1:0] cnt_dual, cnt_single;

  modport slave (
    input  iq_valid, iq_instr0, iq_instr1, iq_pc0, iq_pc1,
           pd_branch0, pd_branch1, pd_trap0, pd_trap1, pd_hilo0, pd_hilo1,
           pd_rs1, pd_rt1, wr_en0, wr_reg0, id_ready, flush, backend_empty,
    output iq_pop, issue_valid, issue_instr0, issue_instr1,
           issue_pc0, issue_pc1, cnt_dual, cnt_single
  );

  modport master (
    output iq_valid, iq_instr0, iq_instr1, iq_pc0, iq_pc1,
           pd_branch0, pd_branch1, pd_trap0, pd_trap1, pd_hilo0, pd_hilo1,
           pd_rs1, pd_rt1, wr_en0, wr_reg0, id_ready, flush, backend_empty,
    input  iq_pop, issue_valid, issue_instr0, issue_instr1,
           issue_pc0, issue_pc1, cnt_dual, cnt_single
  );
endinterface

// File: rtl/issue_pair_check.sv
// Pairing predicate for the two oldest queue entries and the issue count it
// implies, ignoring serialization state.
module issue_pair_check
  import gemini_issue_pkg::*;
(
  input  logic [1:0] iq_valid,
  input  logic       pd_branch0,
  input  logic       pd_branch1,
  input  logic       pd_trap0,
  input  logic       pd_trap1,
  input  logic       pd_hilo0,
  input  logic       pd_hilo1,
  input  logic [4:0] pd_rs1,
  input  logic [4:0] pd_rt1,
  input  logic       wr_en0,
  input  logic [4:0] wr_reg0,
  output logic       pair_ok,
  output logic [1:0] issue_cnt
);

  logic raw_hazard;

  // $0 is hardwired, so a write to it never creates a dependency.
  assign raw_hazard = wr_en0 && (wr_reg0 != 5'd0) &&
                      ((wr_reg0 == pd_rs1) || (wr_reg0 == pd_rt1));

  assign pair_ok = (iq_valid == 2'b11) && !pd_trap0 && !pd_trap1 &&
                   !pd_branch1 && !raw_hazard && !(pd_hilo0 && pd_hilo1);

  always_comb begin
    issue_cnt = POP_NONE;
    if (iq_valid[0]) begin
      if (pair_ok)         issue_cnt = POP_TWO;
      else if (!pd_branch0) issue_cnt = POP_ONE;
    end
  end

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue scheduler: serialization FSM, registered issue stage and
// saturating dual/single issue statistics.
module dual_issue_ctrl
  import gemini_issue_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  dual_issue_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [1:0]       valid_q, valid_d;
  logic [31:0]      instr0_q, instr0_d, instr1_q, instr1_d;
  logic [PC_W-1:0]  pc0_q, pc0_d, pc1_q, pc1_d;
  logic [CNT_W-1:0] dual_q, dual_d, single_q, single_d;

  logic       adv, pair_ok;
  logic [1:0] nominal_cnt, issue_cnt;

  assign adv = bus.id_ready && !bus.flush;

  issue_pair_check u_pair (
    .iq_valid   (bus.iq_valid),
    .pd_branch0 (bus.pd_branch0),
    .pd_branch1 (bus.pd_branch1),
    .pd_trap0   (bus.pd_trap0),
    .pd_trap1   (bus.pd_trap1),
    .pd_hilo0   (bus.pd_hilo0),
    .pd_hilo1   (bus.pd_hilo1),
    .pd_rs1     (bus.pd_rs1),
    .pd_rt1     (bus.pd_rt1),
    .wr_en0     (bus.wr_en0),
    .wr_reg0    (bus.wr_reg0),
    .pair_ok    (pair_ok),
    .issue_cnt  (nominal_cnt)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    issue_cnt = POP_NONE;
    unique case (state_q)
      ST_NORMAL: begin
        if (bus.pd_trap0 && bus.iq_valid[0]) begin
          if (bus.backend_empty) begin
            issue_cnt = POP_ONE;
            state_d   = ST_SERIAL;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          issue_cnt = nominal_cnt;
        end
      end
      ST_DRAIN:  if (bus.backend_empty) state_d = ST_SOLO;
      ST_SOLO: begin
        if (bus.iq_valid[0]) begin
          issue_cnt = POP_ONE;
          state_d   = ST_SERIAL;
        end
      end
      ST_SERIAL: if (bus.backend_empty) state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
    if (!adv) begin
      state_d   = state_q;
      issue_cnt = POP_NONE;
    end
    if (bus.flush) state_d = ST_NORMAL;
  end

  always_comb begin
    valid_d  = valid_q;
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    pc0_d    = pc0_q;
    pc1_d    = pc1_q;
    dual_d   = dual_q;
    single_d = single_q;
    if (bus.flush) begin
      valid_d = 2'b00;
    end else if (adv) begin
      valid_d = (issue_cnt == POP_TWO) ? 2'b11 :
                (issue_cnt == POP_ONE) ? 2'b01 : 2'b00;
      if (issue_cnt != POP_NONE) begin
        instr0_d = bus.iq_instr0;
        pc0_d    = bus.iq_pc0;
      end
      // A single issue leaves slot1 payload untouched; only its valid drops.
      if (issue_cnt == POP_TWO) begin
        instr1_d = bus.iq_instr1;
        pc1_d    = bus.iq_pc1;
        if (dual_q != '1) dual_d = dual_q + 1'b1;
      end
      if (issue_cnt == POP_ONE && single_q != '1) single_d = single_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_NORMAL;
      valid_q  <= 2'b00;
      instr0_q <= '0;
      instr1_q <= '0;
      pc0_q    <= '0;
      pc1_q    <= '0;
      dual_q   <= '0;
      single_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
      dual_q   <= dual_d;
      single_q <= single_d;
    end
  end

  assign bus.iq_pop       = issue_cnt;
  assign bus.issue_valid  = valid_q;
  assign bus.issue_instr0 = instr0_q;
  assign bus.issue_instr1 = instr1_q;
  assign bus.issue_pc0    = pc0_q;
  assign bus.issue_pc1    = pc1_q;
  assign bus.cnt_dual     = dual_q;
  assign bus.cnt_single   = single_q;

endmodule
